// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode pipeline register with a two-entry main/skid buffer.
// Latency: an instruction accepted at cycle t is presented on out_* at t+1 when the main entry is free.
// Backpressure: in_ready = !s_valid (registered only, no combinational path from out_ready).
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_instr/in_pc from fetch; flush redirect;
//        out_valid/out_ready plus decoded fields of the main entry to decode; stall_count (saturating).
module if_id_stage #(
  parameter int N_INSTR = 32,
  parameter int N_PC    = 32,
  parameter int N_CNT   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_INSTR-1:0] in_instr,
  input  logic [N_PC-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         out_opcode,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_shamt,
  output logic [5:0]         out_funct,
  output logic [15:0]        out_immed,
  output logic [25:0]        out_jaddr,
  output logic               out_is_rtype,
  output logic [N_PC-1:0]    out_pc_plus4,
  output logic [N_CNT-1:0]   stall_count
);

  logic               m_valid_q, m_valid_d;
  logic [N_INSTR-1:0] m_instr_q, m_instr_d;
  logic [N_PC-1:0]    m_pc_q,    m_pc_d;
  logic               s_valid_q, s_valid_d;
  logic [N_INSTR-1:0] s_instr_q, s_instr_d;
  logic [N_PC-1:0]    s_pc_q,    s_pc_d;
  logic [N_CNT-1:0]   stall_q,   stall_d;

  logic accept;
  logic drain;

  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign accept    = in_valid && in_ready;
  assign drain     = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;
    stall_d   = stall_q;

    // Stall counting is independent of flush: a flushed cycle can still be a stalled one.
    if (m_valid_q && !out_ready && (stall_q != {N_CNT{1'b1}})) begin
      stall_d = stall_q + N_CNT'(1);
    end

    if (flush) begin
      // Data registers keep their contents; only the valid bits matter.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || drain) begin
      if (s_valid_q) begin
        // Skid entry is older than anything arriving now, so it advances first.
        m_instr_d = s_instr_q;
        m_pc_d    = s_pc_q;
        m_valid_d = 1'b1;
        if (accept) begin
          s_instr_d = in_instr;
          s_pc_d    = in_pc;
        end else begin
          s_valid_d = 1'b0;
        end
      end else begin
        if (accept) begin
          m_instr_d = in_instr;
          m_pc_d    = in_pc;
        end
        m_valid_d = accept;
      end
    end else if (accept) begin
      // Main entry is stuck; accept can only happen here while the skid entry is empty.
      s_instr_d = in_instr;
      s_pc_d    = in_pc;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_instr_q <= '0;
      m_pc_q    <= '0;
      s_valid_q <= 1'b0;
      s_instr_q <= '0;
      s_pc_q    <= '0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_instr_q <= m_instr_d;
      m_pc_q    <= m_pc_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_pc_q    <= s_pc_d;
      stall_q   <= stall_d;
    end
  end

  assign out_opcode   = m_instr_q[31:26];
  assign out_rs       = m_instr_q[25:21];
  assign out_rt       = m_instr_q[20:16];
  assign out_rd       = m_instr_q[15:11];
  assign out_shamt    = m_instr_q[10:6];
  assign out_funct    = m_instr_q[5:0];
  assign out_immed    = m_instr_q[15:0];
  assign out_jaddr    = m_instr_q[25:0];
  assign out_is_rtype = (m_instr_q[31:26] == 6'b000000);
  assign out_pc_plus4 = m_pc_q + N_PC'(4);
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_immed;
  logic [25:0] out_jaddr;
  logic        out_is_rtype;
  logic [31:0] out_pc_plus4;
  logic [3:0]  stall_count;

  int checks = 0;
  int passes = 0;

  // Reference model: ordered list of held {instr, pc}, at most two entries.
  logic [63:0] mq[$];
  int          m_cnt = 0;

  if_id_stage #(.N_INSTR(32), .N_PC(32), .N_CNT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_immed(out_immed),
    .out_jaddr(out_jaddr), .out_is_rtype(out_is_rtype), .out_pc_plus4(out_pc_plus4),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Decoded fields computed arithmetically from the instruction word and pc.
  function automatic logic [106:0] exp_fields(input logic [31:0] i, input logic [31:0] p);
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] im;
    logic [25:0] ja;
    logic [31:0] pp4;
    op  = 6'(i / 32'h0400_0000);
    rs  = 5'((i / 32'h0020_0000) % 32);
    rt  = 5'((i / 32'h0001_0000) % 32);
    rd  = 5'((i / 32'h0000_0800) % 32);
    sh  = 5'((i / 32'h0000_0040) % 32);
    fn  = 6'(i % 64);
    im  = 16'(i % 32'h0001_0000);
    ja  = 26'(i % 32'h0400_0000);
    pp4 = 32'(64'(p) + 64'd4);
    return {op, rs, rt, rd, sh, fn, im, ja, (op == 6'd0), pp4};
  endfunction

  function automatic logic [112:0] exp_vec();
    logic [106:0] f;
    f = '0;
    if (mq.size() > 0) f = exp_fields(mq[0][63:32], mq[0][31:0]);
    return {(mq.size() > 0), (mq.size() < 2), 4'(m_cnt), f};
  endfunction

  function automatic logic [112:0] act_vec();
    logic [106:0] f;
    f = '0;
    if (out_valid) f = {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
                        out_immed, out_jaddr, out_is_rtype, out_pc_plus4};
    return {out_valid, in_ready, stall_count, f};
  endfunction

  // Advance model and DUT by one clock using the currently driven inputs.
  task automatic tick();
    bit acc, drn;
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      drn = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && m_cnt < 15) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back({in_instr, in_pc});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
    checks++; if (stall_count !== 4'd0) $display("FAIL reset_stall got %0d want 0", stall_count); else passes++;
    checks++; if (out_pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4 got %h want 4", out_pc_plus4); else passes++;
    checks++; if (out_is_rtype !== 1'b1) $display("FAIL reset_is_rtype got %b want 1", out_is_rtype); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h2008_FFFF; in_pc = 32'h0;
    tick();
    checks++;
    if ({out_valid, out_opcode, out_rs, out_rt, out_immed, out_is_rtype} !== {1'b1, 6'd8, 5'd0, 5'd8, 16'hFFFF, 1'b0})
      $display("FAIL stream_first got v=%b op=%0d rs=%0d rt=%0d imm=%h r=%b want v=1 op=8 rs=0 rt=8 imm=ffff r=0",
               out_valid, out_opcode, out_rs, out_rt, out_immed, out_is_rtype);
    else passes++;
    in_instr = 32'h0109_5020; in_pc = 32'h4;
    tick();
    checks++;
    if ({out_valid, out_rd, out_funct, out_is_rtype, out_pc_plus4} !== {1'b1, 5'd10, 6'h20, 1'b1, 32'h8})
      $display("FAIL stream_second got v=%b rd=%0d fn=%h r=%b pp4=%h want v=1 rd=10 fn=20 r=1 pp4=8",
               out_valid, out_rd, out_funct, out_is_rtype, out_pc_plus4);
    else passes++;
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL stream_empty got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    a = 32'h8C41_0010; b = 32'h0022_1824; c = 32'h0800_0123;
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = a; in_pc = 32'h100; tick();
    in_instr = b; in_pc = 32'h104; tick();
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else passes++;
    in_instr = c; in_pc = 32'h108; tick();
    checks++;
    if ({out_valid, out_jaddr, out_pc_plus4} !== {1'b1, a[25:0], 32'h104})
      $display("FAIL bp_hold_a got v=%b ja=%h pp4=%h want v=1 ja=%h pp4=104", out_valid, out_jaddr, out_pc_plus4, a[25:0]);
    else passes++;
    out_ready = 1'b1; tick();
    checks++;
    if ({out_valid, out_jaddr, out_pc_plus4} !== {1'b1, b[25:0], 32'h108})
      $display("FAIL bp_then_b got v=%b ja=%h pp4=%h want v=1 ja=%h pp4=108", out_valid, out_jaddr, out_pc_plus4, b[25:0]);
    else passes++;
    tick();
    checks++;
    if ({out_valid, out_jaddr, out_pc_plus4} !== {1'b1, c[25:0], 32'h10C})
      $display("FAIL bp_then_c got v=%b ja=%h pp4=%h want v=1 ja=%h pp4=10c", out_valid, out_jaddr, out_pc_plus4, c[25:0]);
    else passes++;
    in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else passes++;
    checks++; if (stall_count !== 4'(m_cnt)) $display("FAIL bp_stall got %0d want %0d", stall_count, m_cnt); else passes++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h1111_1111; in_pc = 32'h200; tick();
    in_instr = 32'h2222_2222; in_pc = 32'h204; tick();
    flush = 1'b1; in_instr = 32'h3333_3333; in_pc = 32'h208; tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_state got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    else passes++;
    flush = 1'b0; in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_dropped got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_pc_wrap();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_0000; in_pc = 32'hFFFF_FFFC;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_pc_plus4} !== {1'b1, 32'h0}) $display("FAIL pc_wrap got v=%b pp4=%h want v=1 pp4=0", out_valid, out_pc_plus4);
    else passes++;
    tick();
  endtask

  task automatic test_stall_saturate();
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hABCD_0001; in_pc = 32'h40; tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (stall_count !== 4'd10) $display("FAIL stall_mid got %0d want 10", stall_count); else passes++;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (stall_count !== 4'd15) $display("FAIL stall_sat got %0d want 15", stall_count); else passes++;
    checks++; if (out_immed !== 16'h0001) $display("FAIL stall_stable got %h want 0001", out_immed); else passes++;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (stall_count !== 4'd0) $display("FAIL stall_rst got %0d want 0", stall_count); else passes++;
  endtask

  task automatic test_random();
    logic [112:0] e, a;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = $urandom;
      in_pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (k > 350) out_ready = 1'b0;
      tick();
      e = exp_vec();
      a = act_vec();
      checks++;
      if (a !== e) $display("FAIL random_cycle_%0d got %h want %h", k, a, e);
      else passes++;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_pc_wrap();
    test_stall_saturate();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
